// File: rtl/finj_pkg.sv
// Shared types, constants and LFSR tap table for the fault-injection controller.
package finj_pkg;

  localparam int unsigned INJ_CNT_W = 16;

  typedef enum logic [1:0] {
    FINJ_NONE = 2'd0,
    FINJ_FLIP = 2'd1,
    FINJ_SA0  = 2'd2,
    FINJ_SA1  = 2'd3
  } finj_mode_e;

  typedef enum logic [1:0] {
    FINJ_IDLE   = 2'd0,
    FINJ_ARM    = 2'd1,
    FINJ_INJECT = 2'd2
  } finj_state_e;

  // Maximal-length Fibonacci tap masks; bit n-1 set for tap n.
  function automatic logic [31:0] lfsr_taps(int unsigned w);
    unique case (w)
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_D008;
    endcase
  endfunction

endpackage

// File: rtl/finj_lfsr.sv
// Free-running Fibonacci LFSR; exposes its low OUT_W bits as the random target source.
module finj_lfsr
  import finj_pkg::*;
#(
  parameter int unsigned     W     = 16,
  parameter logic [W-1:0]    SEED  = W'(16'hACE1),
  parameter int unsigned     OUT_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [OUT_W-1:0] rnd_o
);

  localparam logic [31:0]  TapsAll = lfsr_taps(W);
  localparam logic [W-1:0] Taps    = TapsAll[W-1:0];

  logic [W-1:0] state_q, state_d;

  always_comb begin
    state_d = {state_q[W-2:0], ^(state_q & Taps)};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign rnd_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/fault_injection_ctrl.sv
// Programmable single-target fault injector (flip / stuck-at) with delay, duration and LFSR targets.
// Build option: FINJ_REARM_EN makes injections repeat until abort.
module fault_injection_ctrl
  import finj_pkg::*;
#(
  parameter int unsigned       NUM_CH    = 4,
  parameter int unsigned       CH_W      = 32,
  parameter int unsigned       LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(16'hACE1),
  parameter int unsigned       DLY_W     = 16,
  parameter int unsigned       DUR_W     = 8,
  localparam int unsigned      CH_IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned      BIT_IDX_W = (CH_W > 1) ? $clog2(CH_W) : 1,
  localparam int unsigned      SIG_W     = NUM_CH * CH_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [1:0]           cfg_mode_i,
  input  logic                 cfg_rand_i,
  input  logic [CH_IDX_W-1:0]  cfg_ch_i,
  input  logic [BIT_IDX_W-1:0] cfg_bit_i,
  input  logic [DLY_W-1:0]     cfg_delay_i,
  input  logic [DUR_W-1:0]     cfg_dur_i,
  input  logic                 abort_i,
  input  logic [SIG_W-1:0]     sig_i,
  output logic [SIG_W-1:0]     sig_o,
  output logic                 inj_active_o,
  output logic [INJ_CNT_W-1:0] inj_count_o
);

  localparam int unsigned RndW = CH_IDX_W + BIT_IDX_W;

  logic [RndW-1:0] rnd;

  finj_lfsr #(
    .W    (LFSR_W),
    .SEED (LFSR_SEED),
    .OUT_W(RndW)
  ) u_lfsr (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .rnd_o (rnd)
  );

  finj_state_e            state_q;
  finj_mode_e             mode_q;
  logic [CH_IDX_W-1:0]    ch_q;
  logic [BIT_IDX_W-1:0]   bit_q;
  logic                   tgt_ok_q;
  logic [DLY_W-1:0]       dly_cnt_q;
  logic [DUR_W-1:0]       dur_cnt_q;
  logic [SIG_W-1:0]       mask_q;
  logic                   active_q;
  logic                   ready_q;
  logic [INJ_CNT_W-1:0]   count_q;
`ifdef FINJ_REARM_EN
  logic                   rand_q;
  logic [DLY_W-1:0]       dly_cfg_q;
  logic [DUR_W-1:0]       dur_cfg_q;
`endif

  logic [CH_IDX_W-1:0]    rnd_ch, sel_ch;
  logic [BIT_IDX_W-1:0]   rnd_bit, sel_bit;
  logic                   sel_ok;
  logic [DUR_W-1:0]       dur_eff;

  function automatic logic [SIG_W-1:0] tgt_mask(logic [CH_IDX_W-1:0] ch,
                                                logic [BIT_IDX_W-1:0] b, logic ok);
    logic [SIG_W-1:0] m;
    m = '0;
    if (ok) m = SIG_W'(1) << (32'(ch) * CH_W + 32'(b));
    return m;
  endfunction

  always_comb begin
    rnd_ch  = CH_IDX_W'(32'(rnd[CH_IDX_W-1:0]) % NUM_CH);
    rnd_bit = BIT_IDX_W'(32'(rnd[CH_IDX_W +: BIT_IDX_W]) % CH_W);
    sel_ch  = cfg_rand_i ? rnd_ch : cfg_ch_i;
    sel_bit = cfg_rand_i ? rnd_bit : cfg_bit_i;
    // Out-of-range explicit targets still run the FSM but never touch sig_o.
    sel_ok  = cfg_rand_i || ((32'(cfg_ch_i) < NUM_CH) && (32'(cfg_bit_i) < CH_W));
    dur_eff = (cfg_dur_i == '0) ? DUR_W'(1) : cfg_dur_i;
  end

`ifdef FINJ_REARM_EN
  logic [CH_IDX_W-1:0]  rearm_ch;
  logic [BIT_IDX_W-1:0] rearm_bit;

  always_comb begin
    rearm_ch  = rand_q ? rnd_ch : ch_q;
    rearm_bit = rand_q ? rnd_bit : bit_q;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= FINJ_IDLE;
      mode_q    <= FINJ_NONE;
      ch_q      <= '0;
      bit_q     <= '0;
      tgt_ok_q  <= 1'b0;
      dly_cnt_q <= '0;
      dur_cnt_q <= '0;
      mask_q    <= '0;
      active_q  <= 1'b0;
      ready_q   <= 1'b1;
      count_q   <= '0;
`ifdef FINJ_REARM_EN
      rand_q    <= 1'b0;
      dly_cfg_q <= '0;
      dur_cfg_q <= '0;
`endif
    end else if (abort_i) begin
      state_q  <= FINJ_IDLE;
      mask_q   <= '0;
      active_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        FINJ_IDLE: begin
          if (cfg_valid_i && ready_q && (cfg_mode_i != FINJ_NONE)) begin
            mode_q    <= finj_mode_e'(cfg_mode_i);
            ch_q      <= sel_ch;
            bit_q     <= sel_bit;
            tgt_ok_q  <= sel_ok;
            dur_cnt_q <= dur_eff;
            ready_q   <= 1'b0;
`ifdef FINJ_REARM_EN
            rand_q    <= cfg_rand_i;
            dly_cfg_q <= cfg_delay_i;
            dur_cfg_q <= dur_eff;
`endif
            // Zero delay skips ARM so the fault lands the cycle after acceptance.
            if (cfg_delay_i == '0) begin
              state_q  <= FINJ_INJECT;
              mask_q   <= tgt_mask(sel_ch, sel_bit, sel_ok);
              active_q <= 1'b1;
            end else begin
              state_q   <= FINJ_ARM;
              dly_cnt_q <= cfg_delay_i;
            end
          end
        end
        FINJ_ARM: begin
          if (dly_cnt_q <= DLY_W'(1)) begin
            state_q  <= FINJ_INJECT;
            mask_q   <= tgt_mask(ch_q, bit_q, tgt_ok_q);
            active_q <= 1'b1;
          end else begin
            dly_cnt_q <= dly_cnt_q - DLY_W'(1);
          end
        end
        FINJ_INJECT: begin
          if (dur_cnt_q <= DUR_W'(1)) begin
            if (count_q != '1) count_q <= count_q + INJ_CNT_W'(1);
`ifdef FINJ_REARM_EN
            ch_q      <= rearm_ch;
            bit_q     <= rearm_bit;
            dur_cnt_q <= dur_cfg_q;
            if (dly_cfg_q == '0) begin
              state_q  <= FINJ_INJECT;
              mask_q   <= tgt_mask(rearm_ch, rearm_bit, tgt_ok_q);
              active_q <= 1'b1;
            end else begin
              state_q   <= FINJ_ARM;
              dly_cnt_q <= dly_cfg_q;
              mask_q    <= '0;
              active_q  <= 1'b0;
            end
`else
            state_q  <= FINJ_IDLE;
            mask_q   <= '0;
            active_q <= 1'b0;
            ready_q  <= 1'b1;
`endif
          end else begin
            dur_cnt_q <= dur_cnt_q - DUR_W'(1);
          end
        end
        default: begin
          state_q  <= FINJ_IDLE;
          mask_q   <= '0;
          active_q <= 1'b0;
          ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // mask_q is zero outside INJECT, so every mode passes sig_i through then.
  always_comb begin
    sig_o = sig_i;
    unique case (mode_q)
      FINJ_NONE: sig_o = sig_i;
      FINJ_FLIP: sig_o = sig_i ^ mask_q;
      FINJ_SA0:  sig_o = sig_i & ~mask_q;
      FINJ_SA1:  sig_o = sig_i | mask_q;
    endcase
  end

  assign cfg_ready_o  = ready_q;
  assign inj_active_o = active_q;
  assign inj_count_o  = count_q;

endmodule
